// File: rtl/rom_read_arbiter_pkg.sv
// Shared types for the dual-requester ROM read arbiter.
// Requester IDs, in-flight tags and the latency range check.
package rom_arb_pkg;

  typedef logic [0:0] req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  function automatic bit latency_ok(input int lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Request/response bundle for the two ROM requesters.
// master = requester side, slave = arbiter side.
interface rom_read_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24
);

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;

  modport master (
    output req0_valid,
    output req0_addr,
    input  req0_ready,
    input  rsp0_valid,
    input  rsp0_data,
    output req1_valid,
    output req1_addr,
    input  req1_ready,
    input  rsp1_valid,
    input  rsp1_data
  );

  modport slave (
    input  req0_valid,
    input  req0_addr,
    output req0_ready,
    output rsp0_valid,
    output rsp0_data,
    input  req1_valid,
    input  req1_addr,
    output req1_ready,
    output rsp1_valid,
    output rsp1_data
  );

endinterface

// File: rtl/rom_read_arbiter_rr.sv
// Two-input round-robin grant with the last-granted pointer.
// Grant is combinational; nothing is granted while reset is high.
module rr_arbiter2
  import rom_arb_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    valid0,
  input  logic    valid1,
  output logic    grant0,
  output logic    grant1,
  output logic    grant_any,
  output req_id_t grant_id
);

  req_id_t last;

  // pick a requester; on a tie the one not granted last wins
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      unique case ({valid1, valid0})
        2'b01: grant0 = 1'b1;
        2'b10: grant1 = 1'b1;
        2'b11: begin
          grant0 = (last == REQ1);
          grant1 = (last == REQ0);
        end
        default: ;
      endcase
    end
  end

  assign grant_any = grant0 | grant1;
  assign grant_id  = grant1 ? REQ1 : REQ0;

  // remember who was served; reset favours requester 0 on the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      last <= REQ1;
    end else if (grant_any) begin
      last <= grant_id;
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one synchronous-read ROM port between two requesters.
// Round-robin issue, tagged fully pipelined responses.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int              ADDR_W  = 18,
  parameter int              DATA_W  = 24,
  parameter int              LATENCY = 1,
  parameter logic [ADDR_W-1:0] BASE_0 = '0,
  parameter logic [ADDR_W-1:0] BASE_1 = '0
) (
  input  logic               clock,
  input  logic               reset,
  rom_read_arbiter_if.slave  bus,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data
);

  localparam int DEPTH = LATENCY + 1;

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("rom_read_arbiter: LATENCY must be 1..4");
  end

  logic        grant0;
  logic        grant1;
  logic        grant_any;
  req_id_t     grant_id;
  logic [ADDR_W-1:0] issue_addr;

  tag_t        tag_pipe [DEPTH];
  tag_t        tag_out;

  logic              rsp0_pulse;
  logic              rsp1_pulse;
  logic [DATA_W-1:0] rsp0_hold;
  logic [DATA_W-1:0] rsp1_hold;

  rr_arbiter2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .valid0    (bus.req0_valid),
    .valid1    (bus.req1_valid),
    .grant0    (grant0),
    .grant1    (grant1),
    .grant_any (grant_any),
    .grant_id  (grant_id)
  );

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // offsets wrap modulo 2^ADDR_W by construction
  assign issue_addr = grant1
    ? bus.req1_addr + BASE_1
    : bus.req0_addr + BASE_0;

  // register the winning address toward the ROM
  always_ff @(posedge clock) begin
    if (reset) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_en <= grant_any;
      if (grant_any) begin
        rom_addr <= issue_addr;
      end
    end
  end

  // tag shift register, aligned so its tail meets valid rom_data
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: grant_any, id: grant_id};
      for (int i = 1; i < DEPTH; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_out = tag_pipe[LATENCY];

  // route returning data to its owner; other side keeps its value
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp0_pulse <= 1'b0;
      rsp1_pulse <= 1'b0;
      rsp0_hold  <= '0;
      rsp1_hold  <= '0;
    end else begin
      rsp0_pulse <= tag_out.valid && (tag_out.id == REQ0);
      rsp1_pulse <= tag_out.valid && (tag_out.id == REQ1);
      if (tag_out.valid && (tag_out.id == REQ0)) begin
        rsp0_hold <= rom_data;
      end
      if (tag_out.valid && (tag_out.id == REQ1)) begin
        rsp1_hold <= rom_data;
      end
    end
  end

  assign bus.rsp0_valid = rsp0_pulse;
  assign bus.rsp0_data  = rsp0_hold;
  assign bus.rsp1_valid = rsp1_pulse;
  assign bus.rsp1_data  = rsp1_hold;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench: two builds (LATENCY 1 and 3 with offsets) on shared stimulus,
// checked against a queue-based transaction model.
module tb_rom_read_arbiter;

  localparam int AW = 18;
  localparam int DW = 24;
  localparam logic [31:0] MASK = 32'h3FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          v0, v1;
  logic [AW-1:0] a0, a1;

  rom_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  rom_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  assign bus_a.req0_valid = v0;
  assign bus_a.req0_addr  = a0;
  assign bus_a.req1_valid = v1;
  assign bus_a.req1_addr  = a1;
  assign bus_b.req0_valid = v0;
  assign bus_b.req0_addr  = a0;
  assign bus_b.req1_valid = v1;
  assign bus_b.req1_addr  = a1;

  logic          en_a, en_b;
  logic [AW-1:0] ra_a, ra_b;
  logic [DW-1:0] rd_a, rd_b;

  rom_read_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LATENCY(1),
    .BASE_0(18'h00000), .BASE_1(18'h00000)
  ) dut_a (
    .clock(clk), .reset(rst), .bus(bus_a.slave),
    .rom_en(en_a), .rom_addr(ra_a), .rom_data(rd_a)
  );

  rom_read_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LATENCY(3),
    .BASE_0(18'h00100), .BASE_1(18'h20000)
  ) dut_b (
    .clock(clk), .reset(rst), .bus(bus_b.slave),
    .rom_en(en_b), .rom_addr(ra_b), .rom_data(rd_b)
  );

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return {6'd0, a} ^ 24'hABCDEF;
  endfunction

  // ROM models: data for an address shows up LATENCY cycles later
  always @(posedge clk) rd_a <= rom_fn(ra_a);

  logic [DW-1:0] pb [3];
  always @(posedge clk) begin
    pb[0] <= rom_fn(ra_b);
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign rd_b = pb[2];

  logic          o_en  [2];
  logic [AW-1:0] o_addr[2];
  logic          o_rdy0[2], o_rdy1[2];
  logic          o_rv0 [2], o_rv1 [2];
  logic [DW-1:0] o_rd0 [2], o_rd1 [2];

  assign o_en[0]   = en_a;
  assign o_en[1]   = en_b;
  assign o_addr[0] = ra_a;
  assign o_addr[1] = ra_b;
  assign o_rdy0[0] = bus_a.req0_ready;
  assign o_rdy0[1] = bus_b.req0_ready;
  assign o_rdy1[0] = bus_a.req1_ready;
  assign o_rdy1[1] = bus_b.req1_ready;
  assign o_rv0[0]  = bus_a.rsp0_valid;
  assign o_rv0[1]  = bus_b.rsp0_valid;
  assign o_rv1[0]  = bus_a.rsp1_valid;
  assign o_rv1[1]  = bus_b.rsp1_valid;
  assign o_rd0[0]  = bus_a.rsp0_data;
  assign o_rd0[1]  = bus_b.rsp0_data;
  assign o_rd1[0]  = bus_a.rsp1_data;
  assign o_rd1[1]  = bus_b.rsp1_data;

  typedef struct {
    int            k;
    int            due;
    int            id;
    logic [DW-1:0] data;
  } pend_t;

  pend_t         pq[$];
  int            lat   [2];
  logic [31:0]   base0 [2];
  logic [31:0]   base1 [2];
  logic          m_en  [2];
  logic [AW-1:0] m_addr[2];
  int            m_last[2];
  logic [DW-1:0] m_held0[2];
  logic [DW-1:0] m_held1[2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_en[k]    = 1'b0;
      m_addr[k]  = '0;
      m_last[k]  = 1;
      m_held0[k] = '0;
      m_held1[k] = '0;
    end
    pq.delete();
  endtask

  // one clock cycle: check registered outputs, apply inputs,
  // check grants, then advance the model across the edge
  task automatic step(input logic r, input logic iv0,
                      input logic [AW-1:0] ia0, input logic iv1,
                      input logic [AW-1:0] ia1);
    pend_t keep[$];
    logic [1:0] ep;
    int g;
    logic [31:0] na;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d_rom_en", k), 32'(o_en[k]), 32'(m_en[k]));
      check($sformatf("d%0d_rom_addr", k), 32'(o_addr[k]),
            32'(m_addr[k]));
      ep = 2'b00;
      keep.delete();
      foreach (pq[i]) begin
        if (pq[i].k == k && pq[i].due == cyc) begin
          ep[pq[i].id] = 1'b1;
          if (pq[i].id == 0) m_held0[k] = pq[i].data;
          else m_held1[k] = pq[i].data;
        end else begin
          keep.push_back(pq[i]);
        end
      end
      pq = keep;
      check($sformatf("d%0d_rsp0_valid", k), 32'(o_rv0[k]), 32'(ep[0]));
      check($sformatf("d%0d_rsp1_valid", k), 32'(o_rv1[k]), 32'(ep[1]));
      check($sformatf("d%0d_rsp0_data", k), 32'(o_rd0[k]),
            32'(m_held0[k]));
      check($sformatf("d%0d_rsp1_data", k), 32'(o_rd1[k]),
            32'(m_held1[k]));
    end
    rst = r;
    v0  = iv0;
    a0  = ia0;
    v1  = iv1;
    a1  = ia1;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (r) g = -1;
      else if (iv0 && iv1) g = (m_last[k] == 1) ? 0 : 1;
      else if (iv0) g = 0;
      else if (iv1) g = 1;
      else g = -1;
      check($sformatf("d%0d_req0_ready", k), 32'(o_rdy0[k]),
            32'(g == 0));
      check($sformatf("d%0d_req1_ready", k), 32'(o_rdy1[k]),
            32'(g == 1));
      if (!r) begin
        m_en[k] = (g >= 0);
        if (g >= 0) begin
          if (g == 0) na = (32'(ia0) + base0[k]) & MASK;
          else na = (32'(ia1) + base1[k]) & MASK;
          m_addr[k] = na[AW-1:0];
          m_last[k] = g;
          pq.push_back('{k: k, due: cyc + 2 + lat[k], id: g,
                         data: rom_fn(na[AW-1:0])});
        end
      end
    end
    if (r) model_reset();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    lat[0]   = 1;
    lat[1]   = 3;
    base0[0] = 32'h0;
    base1[0] = 32'h0;
    base0[1] = 32'h100;
    base1[1] = 32'h20000;
    rst = 1'b1;
    v0  = 1'b0;
    v1  = 1'b0;
    a0  = '0;
    a1  = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // reset held: reset values and no ready even with requests
    step(1'b1, 1'b1, 18'h1, 1'b1, 18'h2);
    step(1'b1, 1'b0, '0, 1'b0, '0);

    // single request from requester 0
    step(1'b0, 1'b1, 18'h00010, 1'b0, '0);
    idle(6);

    // first tie after reset: requester 0 first, then 1
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 18'd5, 1'b1, 18'd9);
    step(1'b0, 1'b0, '0, 1'b1, 18'd9);
    idle(6);

    // sustained contention: strict alternation
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, AW'($urandom_range(0, 'h3FFFF)),
           1'b1, AW'($urandom_range(0, 'h3FFFF)));
    idle(6);

    // offset wrap on both requesters
    step(1'b0, 1'b0, '0, 1'b1, 18'h3FFFF);
    step(1'b0, 1'b1, 18'h3FFFF, 1'b0, '0);
    idle(6);

    // lone requester streaming at full rate
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, '0, 1'b1, AW'($urandom_range(0, 'h3FFFF)));
    idle(6);

    // reset one cycle after three back-to-back requests
    step(1'b0, 1'b1, 18'h00100, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, 18'h00200);
    step(1'b0, 1'b1, 18'h00300, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    idle(8);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) != 0),
           AW'($urandom_range(0, 'h3FFFF)),
           ($urandom_range(0, 3) != 0),
           AW'($urandom_range(0, 'h3FFFF)));
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
